// File: rtl/servo_pkg.sv
// servo_pkg
//   Shared types, default timing constants and the target-duty helper for the
//   servo duty ramp block.
//   Optional feature macro (used by servo_duty_ramp): SERVO_SLEW_LIMIT_EN.
package servo_pkg;

    typedef logic [31:0] duty_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned PERIOD_DEF    = 32'd2_000_000;
    localparam duty_t       MIN_DUTY_DEF  = 32'd100_000;
    localparam duty_t       STEP_LSB_DEF  = 32'd392;
    localparam duty_t       BASE_STEP_DEF = 32'd250;

    // Duty count for a position command, mirrored when the direction bit is set.
    function automatic duty_t calc_tgt(input logic [7:0] pos,
                                       input logic       dir,
                                       input duty_t      min_duty,
                                       input duty_t      step_lsb);
        logic [7:0] eff_pos;
        if (dir) begin
            eff_pos = 8'd255 - pos;
        end else begin
            eff_pos = pos;
        end
        return min_duty + (duty_t'(eff_pos) * step_lsb);
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// servo_frame_timer
//   Free-running frame counter 0..PERIOD-1 that advances only while enabled,
//   holding its value when disabled, and flags the last cycle of each frame.
// Ports
//   clk          in  clock
//   rst_n        in  synchronous active-low reset
//   en_i         in  1 = count, 0 = freeze counter and suppress tick
//   frame_tick_o out one-cycle pulse while the counter sits at PERIOD-1
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD = PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic frame_tick_o
);

    localparam int unsigned    CW   = (PERIOD > 32'd1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]  LAST = CW'(PERIOD - 32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          last_q;
    logic          last_d;

    // Next counter value and registered "at last count" flag.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
        last_d = (cnt_d == LAST);
    end

    // Counter and last-count flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    // A frozen frame produces no tick even while parked on the last count.
    assign frame_tick_o = last_q & en_i;

endmodule

// File: rtl/servo_duty_ramp.sv
// servo_duty_ramp
//   Converts an 8-bit position command plus speed/direction pulses into the
//   32-bit duty count for the PWM stage. Duty moves at most once per frame,
//   on the edge that ends the frame_tick cycle.
//   Macro SERVO_SLEW_LIMIT_EN: defined -> duty steps by BASE_STEP<<rate per
//   frame; undefined -> duty jumps straight to the target at the next tick.
// Ports
//   clk          in   clock (100 MHz)
//   rst_n        in   synchronous active-low reset
//   en           in   1 = run, 0 = freeze duty and frame timer
//   target_pos   in   position command, captured when target_valid=1
//   target_valid in   single-cycle capture strobe
//   speed_up     in   pulse: rate+1 (saturating at 7)
//   slow_down    in   pulse: rate-1 (saturating at 0)
//   dir_switch   in   pulse: toggle direction
//   duty         out  duty count to PWM stage
//   frame_tick   out  one-cycle pulse at frame boundary
//   at_target    out  duty equals effective target
//   rate         out  current rate index
module servo_duty_ramp
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD     = PERIOD_DEF,
    parameter duty_t       MIN_DUTY   = MIN_DUTY_DEF,
    parameter duty_t       STEP_LSB   = STEP_LSB_DEF,
    parameter duty_t       BASE_STEP  = BASE_STEP_DEF,
    parameter logic [7:0]  RESET_POS  = 8'd128,
    parameter logic [2:0]  RESET_RATE = 3'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  target_pos,
    input  logic        target_valid,
    input  logic        speed_up,
    input  logic        slow_down,
    input  logic        dir_switch,
    output logic [31:0] duty,
    output logic        frame_tick,
    output logic        at_target,
    output logic [2:0]  rate
);

    localparam duty_t RESET_DUTY = calc_tgt(RESET_POS, 1'b0, MIN_DUTY, STEP_LSB);

    logic [7:0] pos_q,  pos_d;
    logic       dir_q,  dir_d;
    logic [2:0] rate_q, rate_d;
    duty_t      duty_q, duty_d;
    logic       at_target_q, at_target_d;
    state_t     state_q, state_d;

    logic       frame_tick_s;
    duty_t      tgt_s;
    duty_t      tgt_next_s;
    duty_t      step_s;

    servo_frame_timer #(
        .PERIOD (PERIOD)
    ) u_frame_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .frame_tick_o (frame_tick_s)
    );

    assign tgt_s  = calc_tgt(pos_q, dir_q, MIN_DUTY, STEP_LSB);
    assign step_s = BASE_STEP << rate_q;

    // Command capture, rate tracking, duty update and FSM next state.
    always_comb begin
        pos_d   = pos_q;
        dir_d   = dir_q;
        rate_d  = rate_q;
        duty_d  = duty_q;
        state_d = state_q;

        if (target_valid) begin
            pos_d = target_pos;
        end else begin
            pos_d = pos_q;
        end

        if (dir_switch) begin
            dir_d = ~dir_q;
        end else begin
            dir_d = dir_q;
        end

        // Rate pulses are honoured regardless of en; simultaneous pulses cancel.
        case ({speed_up, slow_down})
            2'b10: begin
                if (rate_q != 3'd7) begin
                    rate_d = rate_q + 3'd1;
                end else begin
                    rate_d = rate_q;
                end
            end
            2'b01: begin
                if (rate_q != 3'd0) begin
                    rate_d = rate_q - 3'd1;
                end else begin
                    rate_d = rate_q;
                end
            end
            default: rate_d = rate_q;
        endcase

        // The tick uses the target as it stood before any same-cycle command.
        if (frame_tick_s && (duty_q != tgt_s)) begin
`ifdef SERVO_SLEW_LIMIT_EN
            if (duty_q < tgt_s) begin
                if ((tgt_s - duty_q) <= step_s) begin
                    duty_d = tgt_s;
                end else begin
                    duty_d = duty_q + step_s;
                end
            end else begin
                if ((duty_q - tgt_s) <= step_s) begin
                    duty_d = tgt_s;
                end else begin
                    duty_d = duty_q - step_s;
                end
            end
`else
            duty_d = tgt_s;
`endif
        end else begin
            duty_d = duty_q;
        end

        case (state_q)
            IDLE: begin
                if (!en) begin
                    state_d = HOLD;
                end else if (tgt_s != duty_q) begin
                    state_d = RAMP;
                end else begin
                    state_d = IDLE;
                end
            end
            RAMP: begin
                if (!en) begin
                    state_d = HOLD;
                end else if (duty_d == tgt_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RAMP;
                end
            end
            HOLD: begin
                if (!en) begin
                    state_d = HOLD;
                end else if (tgt_s != duty_q) begin
                    state_d = RAMP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Compare against next-cycle target so the flag lines up with duty/tgt.
    assign tgt_next_s  = calc_tgt(pos_d, dir_d, MIN_DUTY, STEP_LSB);
    assign at_target_d = (duty_d == tgt_next_s);

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q       <= RESET_POS;
            dir_q       <= 1'b0;
            rate_q      <= RESET_RATE;
            duty_q      <= RESET_DUTY;
            at_target_q <= 1'b1;
            state_q     <= IDLE;
        end else begin
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            rate_q      <= rate_d;
            duty_q      <= duty_d;
            at_target_q <= at_target_d;
            state_q     <= state_d;
        end
    end

    assign duty       = duty_q;
    assign frame_tick = frame_tick_s;
    assign at_target  = at_target_q;
    assign rate       = rate_q;

endmodule
